// File: rtl/ctrl_sequencer.sv
// ID-stage control unit: decodes mode/S/op_code into registered EX/MEM/WB controls,
// with a block-transfer FSM (one memory micro-op per set reg_list bit). Option: WRITEBACK_BASE_EN.
module ctrl_sequencer #(
  parameter int NUM_REGS   = 16,
  parameter int WORD_BYTES = 4,
  parameter int IDX_W      = 4,
  parameter int OFF_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic                cond_pass,
  input  logic                S,
  input  logic [1:0]          mode,
  input  logic [3:0]          op_code,
  input  logic [NUM_REGS-1:0] reg_list,
  output logic [3:0]          EX_command,
  output logic                mem_read,
  output logic                mem_write,
  output logic                WB_en,
  output logic                B,
  output logic                SR_update,
  output logic                has_src1,
  output logic [IDX_W-1:0]    xfer_reg,
  output logic [OFF_W-1:0]    addr_offset,
  output logic                busy
);
  localparam logic [1:0] MODE_ARITHMETIC = 2'b00;
  localparam logic [1:0] MODE_MEM        = 2'b01;
  localparam logic [1:0] MODE_BRANCH     = 2'b10;
  localparam logic [1:0] MODE_BLK        = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                         OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                         OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100,
                         OP_MOV = 4'b1101, OP_MVN = 4'b1111;

  localparam logic [3:0] EX_MOV = 4'd1,  EX_MVN = 4'd2,  EX_ADD = 4'd3,  EX_ADC = 4'd4,
                         EX_SUB = 4'd5,  EX_SBC = 4'd6,  EX_AND = 4'd7,  EX_ORR = 4'd8,
                         EX_EOR = 4'd9,  EX_CMP = 4'd10, EX_TST = 4'd11, EX_LDR = 4'd12,
                         EX_STR = 4'd13;

  localparam logic [OFF_W-1:0] STRIDE = OFF_W'(WORD_BYTES);

  typedef enum logic [1:0] {IDLE, XFER, WBACK} state_t;

  state_t              state;
  logic [NUM_REGS-1:0] mask;
  logic                s_lat;
  logic [OFF_W-1:0]    nxt_off;

  logic [3:0]          arith_ex;
  logic                arith_wb, arith_ok, arith_src1;
  logic [NUM_REGS-1:0] pick_src, pick_rem;
  logic [IDX_W-1:0]    pick_idx;
  logic                more;

  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_REGS-1:0] m);
    lowest = '0;
    for (int i = NUM_REGS-1; i >= 0; i--)
      if (m[i]) lowest = IDX_W'(i);
  endfunction

  always_comb begin
    arith_ex = '0;
    arith_wb = 1'b0;
    arith_ok = 1'b1;
    case (op_code)
      OP_MOV: begin arith_ex = EX_MOV; arith_wb = 1'b1; end
      OP_MVN: begin arith_ex = EX_MVN; arith_wb = 1'b1; end
      OP_ADD: begin arith_ex = EX_ADD; arith_wb = 1'b1; end
      OP_ADC: begin arith_ex = EX_ADC; arith_wb = 1'b1; end
      OP_SUB: begin arith_ex = EX_SUB; arith_wb = 1'b1; end
      OP_SBC: begin arith_ex = EX_SBC; arith_wb = 1'b1; end
      OP_AND: begin arith_ex = EX_AND; arith_wb = 1'b1; end
      OP_ORR: begin arith_ex = EX_ORR; arith_wb = 1'b1; end
      OP_EOR: begin arith_ex = EX_EOR; arith_wb = 1'b1; end
      OP_CMP: arith_ex = EX_CMP;
      OP_TST: arith_ex = EX_TST;
      default: arith_ok = 1'b0;
    endcase
    arith_src1 = arith_ok && (arith_ex != EX_MOV) && (arith_ex != EX_MVN);
  end

  // In IDLE the first micro-op comes straight from the input mask.
  always_comb begin
    pick_src = (state == IDLE) ? reg_list : mask;
    pick_idx = lowest(pick_src);
    pick_rem = pick_src & ~(NUM_REGS'(1) << pick_idx);
    more     = (pick_rem != '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= IDLE;
      mask        <= '0;
      s_lat       <= 1'b0;
      nxt_off     <= '0;
      EX_command  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      WB_en       <= 1'b0;
      B           <= 1'b0;
      SR_update   <= 1'b0;
      has_src1    <= 1'b0;
      xfer_reg    <= '0;
      addr_offset <= '0;
      busy        <= 1'b0;
    end else if (!stall) begin
      EX_command  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      WB_en       <= 1'b0;
      B           <= 1'b0;
      SR_update   <= 1'b0;
      has_src1    <= 1'b0;
      xfer_reg    <= '0;
      addr_offset <= '0;
      busy        <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid && cond_pass) begin
            case (mode)
              MODE_ARITHMETIC: begin
                EX_command <= arith_ex;
                WB_en      <= arith_wb;
                SR_update  <= S && arith_ok;
                has_src1   <= arith_src1;
              end
              MODE_MEM: begin
                EX_command <= S ? EX_LDR : EX_STR;
                mem_read   <= S;
                WB_en      <= S;
                mem_write  <= !S;
                has_src1   <= 1'b1;
              end
              MODE_BRANCH: B <= 1'b1;
              MODE_BLK: begin
                if (reg_list != '0) begin
                  EX_command <= S ? EX_LDR : EX_STR;
                  mem_read   <= S;
                  WB_en      <= S;
                  mem_write  <= !S;
                  has_src1   <= 1'b1;
                  xfer_reg   <= pick_idx;
                  s_lat      <= S;
                  mask       <= pick_rem;
                  nxt_off    <= STRIDE;
`ifdef WRITEBACK_BASE_EN
                  busy       <= 1'b1;
                  state      <= more ? XFER : WBACK;
`else
                  busy       <= more;
                  state      <= more ? XFER : IDLE;
`endif
                end
              end
              default: ;
            endcase
          end
        end
        XFER: begin
          EX_command  <= s_lat ? EX_LDR : EX_STR;
          mem_read    <= s_lat;
          WB_en       <= s_lat;
          mem_write   <= !s_lat;
          has_src1    <= 1'b1;
          xfer_reg    <= pick_idx;
          addr_offset <= nxt_off;
          nxt_off     <= nxt_off + STRIDE;
          mask        <= pick_rem;
`ifdef WRITEBACK_BASE_EN
          busy        <= 1'b1;
          state       <= more ? XFER : WBACK;
`else
          busy        <= more;
          state       <= more ? XFER : IDLE;
`endif
        end
        WBACK: begin
          // nxt_off already equals count*WORD_BYTES here
          EX_command  <= EX_ADD;
          WB_en       <= 1'b1;
          has_src1    <= 1'b1;
          addr_offset <= nxt_off;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; expectations are hand-computed
// and packed as {EX,rd,wr,wb,B,SR,src1,xfer_reg,addr_offset,busy}.
module tb_ctrl_sequencer;
  localparam logic [3:0] EX_MOV = 4'd1, EX_ADD = 4'd3, EX_CMP = 4'd10,
                         EX_LDR = 4'd12, EX_STR = 4'd13;
  localparam logic [3:0] OP_ADD = 4'b0100, OP_MOV = 4'b1101, OP_CMP = 4'b1010;
`ifdef WRITEBACK_BASE_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, flush, cond_pass, S;
  logic [1:0]  mode;
  logic [3:0]  op_code;
  logic [15:0] reg_list;
  logic [3:0]  EX_command;
  logic        mem_read, mem_write, WB_en, B, SR_update, has_src1, busy;
  logic [3:0]  xfer_reg;
  logic [7:0]  addr_offset;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall), .flush(flush),
    .cond_pass(cond_pass), .S(S), .mode(mode), .op_code(op_code), .reg_list(reg_list),
    .EX_command(EX_command), .mem_read(mem_read), .mem_write(mem_write), .WB_en(WB_en),
    .B(B), .SR_update(SR_update), .has_src1(has_src1), .xfer_reg(xfer_reg),
    .addr_offset(addr_offset), .busy(busy)
  );

  wire [22:0] obs = {EX_command, mem_read, mem_write, WB_en, B, SR_update, has_src1,
                     xfer_reg, addr_offset, busy};

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] pk(input logic [3:0] ex, input logic rd, wr, wb, b, sr, s1,
                                     input logic [3:0] xr, input logic [7:0] off, input logic bz);
    return {ex, rd, wr, wb, b, sr, s1, xr, off, bz};
  endfunction

  function automatic logic [22:0] mop(input logic s, input logic [3:0] xr,
                                      input logic [7:0] off, input logic bz);
    return pk(s ? EX_LDR : EX_STR, s, !s, s, 1'b0, 1'b0, 1'b1, xr, off, bz);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] m, input logic s, input logic [3:0] op,
                     input logic [15:0] rl, input logic cp);
    instr_valid = v; mode = m; S = s; op_code = op; reg_list = rl; cond_pass = cp;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv($urandom_range(1), 2'($urandom), $urandom_range(1), 4'($urandom), 16'($urandom), 1'b1);
      tick();
      chk("reset", obs, '0);
    end
    rst = 1'b0;

    drv(1, 2'b00, 1, OP_ADD, '0, 1); tick();
    chk("add_s", obs, pk(EX_ADD, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    drv(1, 2'b00, 0, OP_MOV, '0, 1); tick();
    chk("mov", obs, pk(EX_MOV, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    drv(1, 2'b00, 0, OP_CMP, '0, 1); tick();
    chk("cmp", obs, pk(EX_CMP, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    drv(1, 2'b10, 1, OP_ADD, '0, 1); tick();
    chk("branch", obs, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    drv(1, 2'b01, 1, OP_ADD, '0, 1); tick();
    chk("ldr", obs, pk(EX_LDR, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    drv(1, 2'b01, 0, OP_ADD, '0, 1); tick();
    chk("str", obs, pk(EX_STR, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    drv(1, 2'b00, 1, 4'b0011, '0, 1); tick();
    chk("undef_op", obs, '0);

    // load block r0,r2,r5,r15; inputs during XFER are junk and must be ignored
    drv(1, 2'b11, 1, OP_ADD, 16'h8025, 1); tick();
    chk("ldm0", obs, mop(1, 0, 0, 1));
    drv(1, 2'b00, 0, OP_MOV, 16'hFFFF, 1); tick();
    chk("ldm1", obs, mop(1, 2, 4, 1));
    tick(); chk("ldm2", obs, mop(1, 5, 8, 1));
    tick(); chk("ldm3", obs, mop(1, 15, 12, WB_EN));
`ifdef WRITEBACK_BASE_EN
    tick(); chk("ldm_wb", obs, pk(EX_ADD, 0, 0, 1, 0, 0, 1, 0, 16, 0));
`endif
    drv(1, 2'b00, 1, OP_ADD, '0, 1); tick();
    chk("after_ldm", obs, pk(EX_ADD, 0, 0, 1, 0, 1, 1, 0, 0, 0));

    // store block with a 3-cycle stall on the 2nd micro-op
    drv(1, 2'b11, 0, OP_ADD, 16'h8025, 1); tick();
    chk("stm0", obs, mop(0, 0, 0, 1));
    tick(); chk("stm1", obs, mop(0, 2, 4, 1));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stm_stall", obs, mop(0, 2, 4, 1));
    end
    stall = 1'b0;
    tick(); chk("stm2", obs, mop(0, 5, 8, 1));
    tick(); chk("stm3", obs, mop(0, 15, 12, WB_EN));
`ifdef WRITEBACK_BASE_EN
    tick(); chk("stm_wb", obs, pk(EX_ADD, 0, 0, 1, 0, 0, 1, 0, 16, 0));
`endif

    // flush (with stall) aborts block on the 2nd micro-op
    drv(1, 2'b11, 1, OP_ADD, 16'h00F0, 1); tick();
    chk("blk_f0", obs, mop(1, 4, 0, 1));
    flush = 1'b1; stall = 1'b1; tick();
    chk("flush", obs, '0);
    flush = 1'b0; stall = 1'b0;
    drv(0, 2'b00, 1, OP_ADD, '0, 1); tick();
    chk("no_valid", obs, '0);
    drv(1, 2'b11, 1, OP_ADD, '0, 1); tick();
    chk("blk_empty", obs, '0);
    drv(1, 2'b00, 1, OP_ADD, '0, 0); tick();
    chk("cond_fail", obs, '0);
    drv(1, 2'b00, 1, OP_ADD, '0, 1); tick();
    chk("post_flush", obs, pk(EX_ADD, 0, 0, 1, 0, 1, 1, 0, 0, 0));

    // single-bit mask
    drv(1, 2'b11, 0, OP_ADD, 16'h0400, 1); tick();
    chk("single", obs, mop(0, 10, 0, WB_EN));
`ifdef WRITEBACK_BASE_EN
    tick(); chk("single_wb", obs, pk(EX_ADD, 0, 0, 1, 0, 0, 1, 0, 4, 0));
`endif

    // two-bit mask r0,r1
    drv(1, 2'b11, 1, OP_ADD, 16'h0003, 1); tick();
    chk("pair0", obs, mop(1, 0, 0, 1));
    drv(0, 2'b00, 0, OP_ADD, '0, 1); tick();
    chk("pair1", obs, mop(1, 1, 4, WB_EN));
`ifdef WRITEBACK_BASE_EN
    tick(); chk("pair_wb", obs, pk(EX_ADD, 0, 0, 1, 0, 0, 1, 0, 8, 0));
`endif

    // all-ones mask
    drv(1, 2'b11, 0, OP_ADD, 16'hFFFF, 1);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("ones", obs, mop(0, 4'(i), 8'(i * 4), (i != 15) || WB_EN));
      drv(0, 2'b00, 0, OP_ADD, '0, 1);
    end
`ifdef WRITEBACK_BASE_EN
    tick(); chk("ones_wb", obs, pk(EX_ADD, 0, 0, 1, 0, 0, 1, 0, 64, 0));
`endif
    tick(); chk("idle_end", obs, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised ID-stage control unit: decodes mode/S/op_code into EX/MEM/WB control signals.
- Outputs are registered (ID/EX boundary), with stall and flush support and a condition-fail bubble.
- Adds a block-transfer mode (LDM/STM-style): an FSM expands one instruction into one memory micro-op per set bit of a register list, lowest index first.
- Sits between the instruction decoder and the ID/EX pipeline register; busy freezes fetch/decode.

Parameters:
- NUM_REGS, 16, width of reg_list and number of architectural registers.
- WORD_BYTES, 4, byte stride between consecutive block-transfer addresses.
- IDX_W, 4, width of xfer_reg; must be >= clog2(NUM_REGS).
- OFF_W, 8, width of addr_offset; must hold NUM_REGS*WORD_BYTES.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- instr_valid, input, 1, decoded instruction present this cycle.
- stall, input, 1, hazard stall; hold all state and outputs.
- flush, input, 1, branch-taken flush; kill current and in-progress op.
- cond_pass, input, 1, condition check result for the presented instruction.
- S, input, 1, S bit; load/store select in memory and block modes.
- mode, input, 2, MODE_ARITHMETIC / MODE_MEM / MODE_BRANCH / MODE_BLK (2'b11, added to constants.h).
- op_code, input, 4, OP_* from constants.h.
- reg_list, input, NUM_REGS, block-transfer register mask.
- EX_command, output, 4, EX_* from constants.h.
- mem_read, output, 1, memory read enable.
- mem_write, output, 1, memory write enable.
- WB_en, output, 1, register writeback enable.
- B, output, 1, branch.
- SR_update, output, 1, status register update.
- has_src1, output, 1, Rn operand used (drives hazard unit).
- xfer_reg, output, IDX_W, destination/source register of the current block micro-op.
- addr_offset, output, OFF_W, byte offset from the base for the current micro-op.
- busy, output, 1, sequencer occupied; upstream must hold instruction.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; every output is 0, including EX_command=0 and has_src1=0.
- Latency: one cycle; inputs accepted at edge N appear on outputs after edge N.
- Priority per edge: rst > flush > stall > normal operation.
- flush: outputs clear to 0 and state goes to IDLE, aborting any block transfer; any pending stall is ignored.
- stall (no flush): all outputs and FSM state are held unchanged.
- IDLE, instr_valid=0 or cond_pass=0: bubble (all enables 0, EX_command=0, has_src1=0).
- IDLE, MODE_MEM: S=0 -> EX_STR, mem_write=1. S=1 -> EX_LDR, mem_read=1, WB_en=1.
- IDLE, MODE_ARITHMETIC:
  - MOV/MVN/ADD/ADC/SUB/SBC/AND/ORR/EOR map to the matching EX_* with WB_en=1.
  - CMP/TST map to EX_CMP/EX_TST with WB_en=0.
  - Undefined op_code -> bubble.
  - SR_update=S, in this mode only.
- IDLE, MODE_BRANCH: B=1, EX_command=0.
- has_src1 = 0 for EX_MOV, EX_MVN, branch and bubble; 1 otherwise.
- IDLE, MODE_BLK, reg_list==0: bubble, no FSM entry.
- IDLE, MODE_BLK, reg_list!=0:
  - Latch reg_list and S; go to XFER.
  - First micro-op is emitted on the same edge: lowest set bit i, xfer_reg=i, addr_offset=0.
  - EX_command=EX_LDR/EX_STR, with mem_read+WB_en or mem_write as in MODE_MEM; has_src1=1.
- XFER, each non-stalled edge:
  - Clear the serviced bit.
  - Emit the next lowest set bit; addr_offset += WORD_BYTES.
- busy = 1 while latched mask is non-zero after the current op, i.e. busy is high on all block micro-ops except the last.
- Last micro-op issued -> state=IDLE (busy=0), so a new instruction is accepted the next edge.
- Single-bit mask: one micro-op, busy never asserts.
- All-ones mask: NUM_REGS micro-ops; final addr_offset=(NUM_REGS-1)*WORD_BYTES.
- instr_valid/mode/reg_list are ignored while in XFER.

Optional Feature:
WRITEBACK_BASE_EN:
- Defined: after the last micro-op of a block transfer, one extra cycle is emitted with EX_command=EX_ADD, WB_en=1, mem_read=mem_write=0, has_src1=1, xfer_reg=0, addr_offset=count*WORD_BYTES (base update). busy stays high through the last micro-op; the extra cycle itself is the final one (busy=0). flush during the extra cycle cancels it.
- Undefined: no writeback cycle; the behaviour is exactly as above.

Test Plan:
- Assert rst for 2 cycles with random inputs -> all outputs 0; state IDLE.
- MODE_ARITHMETIC OP_ADD S=1, then OP_MOV, then OP_CMP -> next cycles: (EX_ADD, WB_en=1, SR_update=1, has_src1=1), (EX_MOV, WB_en=1, has_src1=0), (EX_CMP, WB_en=0, has_src1=1).
- MODE_BLK S=1 reg_list=16'h8025 -> 4 micro-ops, xfer_reg 0,2,5,15; addr_offset 0,4,8,12; mem_read=WB_en=1; busy 1,1,1,0; then accepts next instruction.
- Same block, S=0, with stall high during the 2nd micro-op for 3 cycles -> outputs frozen at xfer_reg=2, addr_offset=4; sequence resumes unchanged.
- MODE_BLK reg_list=16'h00F0, flush on the 2nd micro-op -> next cycle all outputs 0, busy=0, state IDLE; reg_list=0 and cond_pass=0 inputs produce a bubble.
- With WRITEBACK_BASE_EN, reg_list=16'h0003 -> micro-ops r0, r1, then EX_ADD WB_en=1 addr_offset=8.
